// File: rtl/vc_test_pkg.sv
// Shared types and constants for the random-delay test source/sink pair:
// source FSM state encoding and the 32-bit Galois LFSR step.
package vc_test_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_DELAY,
    ST_SEND,
    ST_DONE
  } vc_src_state_t;

  localparam logic [31:0] VC_LFSR32_TAPS = 32'h8020_0003;

  // Right-shifting Galois step; bit 31 is a tap, so a nonzero state stays nonzero.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? VC_LFSR32_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/vc_Lfsr32.sv
// 32-bit Galois LFSR that advances one step per cycle when en is high.
// Shared by the random-delay source and sink so both see the same sequence.
module vc_Lfsr32
  import vc_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] out
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = en ? lfsr32_next(lfsr_q) : lfsr_q;
  end

  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// Test source: streams num_msgs messages from a preloaded memory over a
// val/rdy interface, inserting LFSR-driven random bubbles between messages.
module vc_test_rand_delay_source
  import vc_test_pkg::*;
#(
  parameter int          p_msg_sz    = 1,
  parameter int          p_mem_sz    = 1024,
  parameter int          p_max_delay = 0,
  parameter logic [31:0] p_seed      = 32'hB9B9B9B9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(p_mem_sz)-1:0] wr_addr,
  input  logic [p_msg_sz-1:0]         wr_msg,
  input  logic [$clog2(p_mem_sz):0]   num_msgs,
  output logic                        val,
  input  logic                        rdy,
  output logic [p_msg_sz-1:0]         msg,
  output logic                        done
);

  localparam int AW = $clog2(p_mem_sz);
  localparam int IW = AW + 1;
  localparam int CW = $clog2(p_max_delay + 2);

  logic [p_msg_sz-1:0] m [p_mem_sz];

  vc_src_state_t state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   lfsr_out;
  logic [CW-1:0] delay;
  logic          hs;
  logic          draw;

  // NOTE: the message memory has no reset, so contents loaded during reset survive it.
  always_ff @(posedge clk) begin
    if (wr_en) m[wr_addr] <= wr_msg;
  end

  assign hs   = (state_q == ST_SEND) && rdy;
  assign draw = (state_q == ST_INIT) || hs;

  vc_Lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (draw),
    .seed  (p_seed),
    .out   (lfsr_out)
  );

  assign delay = CW'(lfsr_out % 32'(p_max_delay + 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      index_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    case (state_q)
      ST_INIT, ST_SEND: begin
        if (draw) begin
          if (hs) index_d = index_q + IW'(1);
          if (index_d == num_msgs) begin
            state_d = ST_DONE;
          end else if (delay == '0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_DELAY;
            count_d = delay;
          end
        end
      end
      ST_DELAY: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = ST_SEND;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_comb begin
    val  = (state_q == ST_SEND);
    done = (state_q == ST_DONE);
  end

  // Combinational read keeps msg aligned with val in the same cycle.
  assign msg = m[index_q[AW-1:0]];

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Self-checking bench: three sources (max delay 0, 5, 3) share inputs; each
// stream is checked against a transaction-level model of order and bubble gaps.
module tb_vc_test_rand_delay_source;

  localparam int          MSG_W = 8;
  localparam int          MEM_N = 64;
  localparam int          AW    = 6;
  localparam int          IW    = 7;
  localparam logic [31:0] SEED  = 32'hB9B9B9B9;
  localparam logic [31:0] TAPS  = 32'h80200003;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [MSG_W-1:0] wr_msg;
  logic [IW-1:0]    num_msgs;
  logic             rdy;

  logic             val0, val1, val2;
  logic             done0, done1, done2;
  logic [MSG_W-1:0] msg0, msg1, msg2;

  logic [MSG_W-1:0] mem_ref [MEM_N];

  int               sel;
  logic             val_s, done_s;
  logic [MSG_W-1:0] msg_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vc_test_rand_delay_source #(.p_msg_sz(MSG_W), .p_mem_sz(MEM_N), .p_max_delay(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_msg(wr_msg),
    .num_msgs(num_msgs), .val(val0), .rdy(rdy), .msg(msg0), .done(done0)
  );

  vc_test_rand_delay_source #(.p_msg_sz(MSG_W), .p_mem_sz(MEM_N), .p_max_delay(5)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_msg(wr_msg),
    .num_msgs(num_msgs), .val(val1), .rdy(rdy), .msg(msg1), .done(done1)
  );

  vc_test_rand_delay_source #(.p_msg_sz(MSG_W), .p_mem_sz(MEM_N), .p_max_delay(3)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_msg(wr_msg),
    .num_msgs(num_msgs), .val(val2), .rdy(rdy), .msg(msg2), .done(done2)
  );

  always_comb begin
    case (sel)
      1:       begin val_s = val1; done_s = done1; msg_s = msg1; end
      2:       begin val_s = val2; done_s = done2; msg_s = msg2; end
      default: begin val_s = val0; done_s = done0; msg_s = msg0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] t;
    t = x >> 1;
    if (x[0]) t = t ^ TAPS;
    return t;
  endfunction

  task automatic write_mem(input int addr, input logic [MSG_W-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_msg  = data;
    mem_ref[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Release just after a rising edge so the next falling-edge sample is the
  // first cycle out of reset.
  task automatic release_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    rdy      = 1'b0;
    num_msgs = IW'(n);
    release_reset();
  endtask

  // rdy_mode: 0 = always ready, 1 = stall samples 3..5, 2 = random ready.
  // stop_after >= 0 returns on the sample whose handshake completes at the next edge.
  task automatic run_stream(input int inst, input int dmax, input int n,
                            input int rdy_mode, input int stop_after);
    int          gaps[$];
    logic [31:0] lf;
    int          k, idle, cyc, budget, exp_idle;
    bit          in_msg;
    sel    = inst;
    lf     = SEED;
    for (int i = 0; i < n; i++) begin
      gaps.push_back(int'(lf % 32'(dmax + 1)));
      lf = lfsr_step(lf);
    end
    k      = 0;
    idle   = 0;
    cyc    = 0;
    in_msg = 1'b0;
    budget = 200 + n * 40;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc >= 3 && cyc <= 5);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (k == n && (n > 0 || cyc >= 2)) begin
        check($sformatf("done_i%0d", inst), 32'(done_s), 32'd1);
        check($sformatf("val_after_done_i%0d", inst), 32'(val_s), 32'd0);
        repeat (3) begin
          @(negedge clk);
          rdy = 1'($urandom_range(0, 1));
          check($sformatf("done_hold_i%0d", inst), 32'({done_s, val_s}), 32'b10);
        end
        return;
      end
      if (!val_s) begin
        idle++;
        if (in_msg) check($sformatf("val_held_i%0d_k%0d", inst, k), 32'(val_s), 32'd1);
        in_msg = 1'b0;
      end else begin
        if (!in_msg) begin
          exp_idle = gaps[k] + ((k == 0) ? 1 : 0);
          check($sformatf("gap_i%0d_k%0d", inst, k), 32'(idle), 32'(exp_idle));
          check($sformatf("msg_i%0d_k%0d", inst, k), 32'(msg_s), 32'(mem_ref[k]));
          check($sformatf("done_low_i%0d_k%0d", inst, k), 32'(done_s), 32'd0);
          in_msg = 1'b1;
        end else begin
          check($sformatf("msg_stall_i%0d_k%0d", inst, k), 32'(msg_s), 32'(mem_ref[k]));
        end
        check($sformatf("msg_known_i%0d", inst), 32'($isunknown(msg_s)), 32'd0);
        if (rdy) begin
          k++;
          idle   = 0;
          in_msg = 1'b0;
          if (k == stop_after) return;
        end
      end
    end
    check($sformatf("timeout_i%0d", inst), 32'(k), 32'(n));
  endtask

  initial begin
    reset    = 1'b1;
    rdy      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_msg   = '0;
    num_msgs = IW'(4);
    sel      = 0;

    // Memory is loaded while reset is held; it must survive every later reset.
    write_mem(0, 8'h11);
    write_mem(1, 8'h22);
    write_mem(2, 8'h33);
    write_mem(3, 8'h44);
    for (int i = 4; i < MEM_N; i++) write_mem(i, MSG_W'($urandom));

    check("rst_val0",  32'(val0),  32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_val1",  32'(val1),  32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_val2",  32'(val2),  32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    check("rst_msg0",  32'(msg0),  32'h11);

    // Back-to-back stream, no delay.
    release_reset();
    run_stream(0, 0, 4, 0, -1);

    // Mid-stream stall of three cycles.
    do_reset(4);
    run_stream(0, 0, 4, 1, -1);

    // Random gaps up to 5.
    do_reset(8);
    run_stream(1, 5, 8, 0, -1);

    // Nothing to send.
    do_reset(0);
    run_stream(0, 0, 0, 2, -1);

    // Asynchronous reset after two handshakes, then full replay.
    do_reset(4);
    run_stream(1, 5, 4, 0, 2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_val1",  32'(val1),  32'd0);
    check("async_done1", 32'(done1), 32'd0);
    check("async_msg1",  32'(msg1),  32'h11);
    check("async_val0",  32'({val0, done0}), 32'd0);
    check("async_val2",  32'({val2, done2}), 32'd0);
    release_reset();
    run_stream(1, 5, 4, 0, -1);

    // Long stream against a randomly ready sink.
    do_reset(64);
    run_stream(2, 3, 64, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
